// File: rtl/four_to_one_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : four_to_one_arbiter
// Function : Round-robin 4:1 arbiter/sequencer with burst cap, driving the
//            shared mux selector and a valid/ready output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module four_to_one_arbiter #(
  parameter int WIDTH    = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            req_i,
  input  logic [3:0][WIDTH-1:0] in_data_i,
  output logic [3:0]            gnt_o,
  output logic [1:0]            sel_o,
  output logic [WIDTH-1:0]      out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  busy_o
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  localparam logic [3:0] C_LAST = 4'(MAX_HOLD - 1);

  state_t     state_q;
  logic [3:0] gnt_q;
  logic [1:0] sel_q;
  logic [1:0] ptr_q;
  logic [3:0] cnt_q;
  logic       busy_q;

  logic [1:0] w_base;
  logic [1:0] w_win;
  logic       w_found;
  logic       w_xfer;
  logic       w_release;

  // In GRANT the search base is only consumed on a release, where the new
  // pointer value sel+1 is already the one to arbitrate against.
  always_comb begin
    w_base  = (state_q == S_GRANT) ? (sel_q + 2'd1) : ptr_q;
    w_found = 1'b0;
    w_win   = w_base;
    for (int k = 0; k < 4; k++) begin
      if (!w_found && req_i[w_base + 2'(k)]) begin
        w_found = 1'b1;
        w_win   = w_base + 2'(k);
      end
    end
  end

  assign w_xfer    = (state_q == S_GRANT) && req_i[sel_q] && out_ready_i;
  assign w_release = (state_q == S_GRANT) &&
                     (!req_i[sel_q] || (w_xfer && (cnt_q == C_LAST)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_found) begin
            state_q <= S_GRANT;
            gnt_q   <= 4'b0001 << w_win;
            sel_q   <= w_win;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b1;
          end else begin
            gnt_q   <= 4'b0000;
          end
        end
        S_GRANT: begin
          if (w_release) begin
            ptr_q <= sel_q + 2'd1;
            if (w_found) begin
              gnt_q <= 4'b0001 << w_win;
              sel_q <= w_win;
              cnt_q <= 4'd0;
            end else begin
              state_q <= S_IDLE;
              gnt_q   <= 4'b0000;
              cnt_q   <= 4'd0;
              busy_q  <= 1'b0;
            end
          end else if (w_xfer) begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          gnt_q   <= 4'b0000;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_o       = gnt_q;
  assign sel_o       = sel_q;
  assign busy_o      = busy_q;
  assign out_valid_o = (state_q == S_GRANT) && req_i[sel_q];
  assign out_data_o  = in_data_i[sel_q];

endmodule
`default_nettype wire

// File: tb/tb_four_to_one_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_four_to_one_arbiter
// Function : Scoreboard bench for four_to_one_arbiter, MAX_HOLD=4 and =1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_four_to_one_arbiter;

  localparam int W = 32;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] s;
    logic       b;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic [3:0]          req = 4'b0000;
  logic [3:0][W-1:0]   in_data;
  logic                out_ready = 1'b0;

  logic [3:0]   gnt4, gnt1;
  logic [1:0]   sel4, sel1;
  logic [W-1:0] out_data4, out_data1;
  logic         out_valid4, out_valid1, busy4, busy1;

  always #5 clk = ~clk;

  four_to_one_arbiter #(.WIDTH(W), .MAX_HOLD(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req_i(req), .in_data_i(in_data),
    .gnt_o(gnt4), .sel_o(sel4), .out_data_o(out_data4),
    .out_valid_o(out_valid4), .out_ready_i(out_ready), .busy_o(busy4)
  );

  four_to_one_arbiter #(.WIDTH(W), .MAX_HOLD(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_i(req), .in_data_i(in_data),
    .gnt_o(gnt1), .sel_o(sel1), .out_data_o(out_data1),
    .out_valid_o(out_valid1), .out_ready_i(out_ready), .busy_o(busy1)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state, index 0 -> MAX_HOLD=4 instance, 1 -> MAX_HOLD=1
  logic [3:0] m_gnt  [2];
  logic [1:0] m_sel  [2];
  logic [1:0] m_ptr  [2];
  logic [3:0] m_cnt  [2];
  logic       m_busy [2];
  int         hold   [2] = '{4, 1};

  exp_t         eq4[$], eq1[$];
  logic [W-1:0] xq4[$], xq1[$];
  logic [1:0]   own4[$], own1[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [3:0] f_gnt(input int k);
    return (k == 0) ? gnt4 : gnt1;
  endfunction
  function automatic logic [1:0] f_sel(input int k);
    return (k == 0) ? sel4 : sel1;
  endfunction
  function automatic logic f_busy(input int k);
    return (k == 0) ? busy4 : busy1;
  endfunction
  function automatic logic f_valid(input int k);
    return (k == 0) ? out_valid4 : out_valid1;
  endfunction
  function automatic logic [W-1:0] f_data(input int k);
    return (k == 0) ? out_data4 : out_data1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_gnt[k] = 4'b0000; m_sel[k] = 2'd0; m_ptr[k] = 2'd0;
      m_cnt[k] = 4'd0;    m_busy[k] = 1'b0;
    end
  endtask

  task automatic model_next(input int k, input logic [3:0] r, input logic rdy, output logic xfer);
    logic       rel, found;
    logic [1:0] base, w, c;
    xfer  = m_busy[k] && r[m_sel[k]] && rdy;
    rel   = m_busy[k] && (!r[m_sel[k]] || (xfer && (int'(m_cnt[k]) == hold[k] - 1)));
    base  = m_busy[k] ? m_sel[k] + 2'd1 : m_ptr[k];
    found = 1'b0;
    w     = 2'd0;
    for (int j = 0; j < 4; j++) begin
      c = base + 2'(j);
      if (!found && r[c]) begin found = 1'b1; w = c; end
    end
    if (!m_busy[k] || rel) begin
      if (rel) m_ptr[k] = m_sel[k] + 2'd1;
      m_cnt[k] = 4'd0;
      if (found) begin
        m_busy[k] = 1'b1; m_gnt[k] = 4'b0001 << w; m_sel[k] = w;
      end else begin
        m_busy[k] = 1'b0; m_gnt[k] = 4'b0000;
      end
    end else if (xfer) begin
      m_cnt[k] = m_cnt[k] + 4'd1;
    end
  endtask

  // One clock of stimulus; entered and left at posedge+1.
  task automatic step(input logic [3:0] r, input logic rdy);
    logic         x, ev;
    logic [W-1:0] ed;
    exp_t         e;
    req = r; out_ready = rdy;
    #1;
    for (int k = 0; k < 2; k++) begin
      ev = m_busy[k] && r[m_sel[k]];
      ed = in_data[m_sel[k]];
      chk($sformatf("d%0d_valid", k), 32'(f_valid(k)), 32'(ev));
      chk($sformatf("d%0d_data", k), f_data(k), ed);
      model_next(k, r, rdy, x);
      if (x) begin
        if (k == 0) xq4.push_back(ed); else xq1.push_back(ed);
      end
      e.g = m_gnt[k]; e.s = m_sel[k]; e.b = m_busy[k];
      if (k == 0) eq4.push_back(e); else eq1.push_back(e);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      e = (k == 0) ? eq4.pop_front() : eq1.pop_front();
      chk($sformatf("d%0d_gnt", k), 32'(f_gnt(k)), 32'(e.g));
      chk($sformatf("d%0d_sel", k), 32'(f_sel(k)), 32'(e.s));
      chk($sformatf("d%0d_busy", k), 32'(f_busy(k)), 32'(e.b));
    end
  endtask

  // mid=1 asserts reset between clock edges of a running cycle.
  task automatic do_reset(input bit mid, input string tag);
    if (mid) #3;
    rst_n = 1'b0; req = 4'b0000;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_d%0d_gnt", tag, k), 32'(f_gnt(k)), 32'd0);
      chk($sformatf("%s_d%0d_sel", tag, k), 32'(f_sel(k)), 32'd0);
      chk($sformatf("%s_d%0d_busy", tag, k), 32'(f_busy(k)), 32'd0);
      chk($sformatf("%s_d%0d_valid", tag, k), 32'(f_valid(k)), 32'd0);
      chk($sformatf("%s_d%0d_data", tag, k), f_data(k), in_data[0]);
    end
    chk($sformatf("%s_xq4_drained", tag), xq4.size(), 0);
    chk($sformatf("%s_xq1_drained", tag), xq1.size(), 0);
    model_reset();
    own4.delete(); own1.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic set_data();
    for (int i = 0; i < 4; i++) in_data[i] = {4'(i + 1), 28'($urandom)};
  endtask

  // Transfer monitor, sampled mid-cycle while inputs are stable.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid4 && out_ready) begin
        chk("d0_xfer_expected", 32'(xq4.size() != 0), 32'd1);
        if (xq4.size() != 0) chk("d0_xfer_data", out_data4, xq4.pop_front());
        own4.push_back(sel4);
      end
      if (out_valid1 && out_ready) begin
        chk("d1_xfer_expected", 32'(xq1.size() != 0), 32'd1);
        if (xq1.size() != 0) chk("d1_xfer_data", out_data1, xq1.pop_front());
        own1.push_back(sel1);
      end
    end
  end

  initial begin
    set_data();
    model_reset();
    #2;
    do_reset(1'b0, "rst0");

    // Single requester, three transfers, then withdrawal
    repeat (4) step(4'b0001, 1'b1);
    repeat (2) step(4'b0000, 1'b1);
    chk("p1_count", own4.size(), 3);
    for (int j = 0; j < 3; j++)
      if (j < own4.size()) chk($sformatf("p1_own_%0d", j), 32'(own4[j]), 32'd0);

    // All requesting: bursts of 4 rotate 0,1,2,3,0 with no bubbles
    set_data();
    do_reset(1'b0, "rst1");
    repeat (21) step(4'b1111, 1'b1);
    chk("p2_count4", own4.size(), 20);
    for (int j = 0; j < 20; j++)
      if (j < own4.size()) chk($sformatf("p2_own4_%0d", j), 32'(own4[j]), (j / 4) % 4);
    chk("p2_count1", own1.size(), 20);
    for (int j = 0; j < 20; j++)
      if (j < own1.size()) chk($sformatf("p2_own1_%0d", j), 32'(own1[j]), j % 4);

    // Fairness on 1010: MAX_HOLD=1 alternates 1,3 each cycle
    set_data();
    do_reset(1'b0, "rst2");
    repeat (9) step(4'b1010, 1'b1);
    chk("p3_count1", own1.size(), 8);
    for (int j = 0; j < 8; j++)
      if (j < own1.size()) chk($sformatf("p3_own1_%0d", j), 32'(own1[j]), (j % 2 == 0) ? 1 : 3);
    for (int j = 0; j < 8; j++)
      if (j < own4.size()) chk($sformatf("p3_own4_%0d", j), 32'(own4[j]), (j < 4) ? 1 : 3);

    // Backpressure on owner 2, count resumes afterwards
    set_data();
    do_reset(1'b0, "rst3");
    step(4'b0100, 1'b1);
    step(4'b0101, 1'b1);
    repeat (5) step(4'b0101, 1'b0);
    chk("p4_hold_gnt", 32'(gnt4), 32'b0100);
    repeat (3) step(4'b0101, 1'b1);
    chk("p4_handover_gnt", 32'(gnt4), 32'b0001);
    step(4'b0101, 1'b1);
    chk("p4_count4", own4.size(), 5);
    for (int j = 0; j < 5; j++)
      if (j < own4.size()) chk($sformatf("p4_own4_%0d", j), 32'(own4[j]), (j < 4) ? 2 : 0);

    // Withdrawal of owner 1 after two transfers; 3 beats newly raised 0
    set_data();
    do_reset(1'b0, "rst4");
    repeat (3) step(4'b1010, 1'b1);
    step(4'b1001, 1'b1);
    chk("p5_gnt_after_drop", 32'(gnt4), 32'b1000);
    step(4'b1001, 1'b1);
    chk("p5_count4", own4.size(), 3);
    for (int j = 0; j < 3; j++)
      if (j < own4.size()) chk($sformatf("p5_own4_%0d", j), 32'(own4[j]), (j < 2) ? 1 : 3);

    // Asynchronous reset while owner 2 holds the grant
    set_data();
    do_reset(1'b0, "rst5");
    repeat (6) step(4'b0110, 1'b1);
    chk("p6_pre_sel", 32'(sel4), 32'd2);
    do_reset(1'b1, "arst");
    step(4'b1010, 1'b1);
    chk("p6_first_sel4", 32'(sel4), 32'd1);
    chk("p6_first_sel1", 32'(sel1), 32'd1);
    step(4'b1010, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    chk("end_xq4_drained", xq4.size(), 0);
    chk("end_xq1_drained", xq1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/four_to_one_arbiter.md
# four_to_one_arbiter

Round-robin arbiter and sequencer that shares one 4:1 output path among four requesters in the CAM validation datapath. It owns the 2-bit selector of the four-to-one mux, grants one requester at a time, and moves that requester's data to a single output with a valid/ready handshake. Each grant is capped by a burst limit so that no requester can starve the others.

## Interface
- WIDTH, 32, data width per requester and of the output.
- MAX_HOLD, 4, maximum number of accepted transfers per grant (legal range 1–15).

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- req  in  4  request per requester; bit i is requester i.
- in_data  in  4×WIDTH  data per requester; in_data[i] belongs to requester i.
- gnt  out  4  one-hot grant, or all zeros when no requester is granted.
- sel  out  2  mux selector, equal to the encoded index of the current or last owner.
- out_data  out  WIDTH  in_data[sel], combinational.
- out_valid  out  1  high when the current owner presents data.
- out_ready  in  1  downstream accept.
- busy  out  1  high whenever the arbiter is in the GRANT state.

## Operation
- The state machine has two states, IDLE and GRANT. Registers are state, gnt, sel, ptr (2 b, rotating priority), and cnt (4 b, transfers in the current grant).
- Winner selection: the first i with req[i]=1, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- IDLE behaviour:
  - If req≠0: go to GRANT, load gnt = one-hot(winner), sel = winner, cnt = 0.
  - Otherwise stay in IDLE with gnt = 0. sel keeps its previous value.
- GRANT outputs: out_valid = req[sel]. A transfer occurs when out_valid && out_ready. Each transfer increments cnt.
- A release occurs in GRANT when either of the following holds:
  - req[sel]=0, or
  - a transfer occurs with cnt == MAX_HOLD−1.
- In the release cycle:
  - ptr ← sel+1 (mod 4).
  - The winner is evaluated in that same cycle against the new pointer value sel+1, excluding no requester.
  - If req≠0, load the new grant with no idle bubble (state stays GRANT, cnt = 0).
  - Otherwise go to IDLE with gnt = 0.
- Backpressure: while out_ready=0 and req[sel]=1, all of gnt, sel, cnt and ptr hold. out_data follows in_data[sel].
- Requester obligation: hold req high and in_data stable until the transfer is accepted. Lowering req while owning the grant is legal and causes a release with no transfer.
- out_valid is never high in IDLE.

## Timing
- Reset values (asynchronous, taking effect immediately): state=IDLE, gnt=0, sel=0, ptr=0, cnt=0, busy=0, out_valid=0. out_data=in_data[0].
- Grant latency: req rises in an IDLE cycle t, then gnt and busy are high from t+1 and out_valid is high from t+1.
- Back-to-back handover: the release edge loads the next owner, so its first transfer can occur in the very next cycle. Throughput is 1 transfer per cycle under continuous requests.
- Burst length: with out_ready held at 1, each owner makes exactly min(MAX_HOLD, its pending transfers) consecutive transfers.
- Simultaneous events: a new req arriving in the release cycle is eligible for that cycle's arbitration.
- Reset mid-grant: all state clears at once. No partial transfer is counted, and after rst_n rises the arbiter restarts from ptr=0.
- gnt, sel and busy are registered outputs. out_valid and out_data are combinational from registered sel/state and the inputs.

## Test plan
- Reset then single request: hold req=0001 for 3 transfers with out_ready=1.
  - Required: gnt=0001 and sel=0 one cycle after req.
  - Required: 3 transfers carry in_data[0].
  - Required: after req drops, gnt=0 and busy=0 on the following edge.
- All request, MAX_HOLD=4, out_ready=1:
  - Required: grants in the order 0,1,2,3,0, with each owner getting 4 consecutive transfers and no idle cycles between owners.
- Fairness, MAX_HOLD=1, req=1010 held continuously:
  - Required: sel alternates 1,3,1,3 with one transfer per cycle, and ptr wraps from 3 to 0 correctly.
- Backpressure: owner 2 is granted, then out_ready=0 for 5 cycles.
  - Required: gnt, sel and cnt are stable, out_valid=1 and out_data=in_data[2].
  - Required: when out_ready returns, the transfer count resumes from the held value.
- Withdrawal: owner 1 drops req mid-burst after 2 transfers while req[3]=1.
  - Required: release occurs in that cycle and gnt=1000 on the next edge.
  - Required: ptr=2, so 3 wins over a simultaneously raised req[0].
- Asynchronous reset during GRANT: assert rst_n=0 between edges.
  - Required: gnt=0, out_valid=0 and sel=0 immediately, without waiting for a clock edge.
  - Required: the first grant after reset follows ptr=0 priority.
